// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings, parity modes and line decode
package uart_pkg;

  // Transmitter/receiver frame phases. SYNC is the wait for the first bit
  // boundary after a byte is taken, so the start bit is always full length.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Serial line level for a given frame phase. Idle, sync and stop all hold
  // the line high; only start forces it low.
  function automatic logic line_level(input state_t st, input logic data_bit,
                                      input logic parity_bit);
    logic lvl;
    lvl = 1'b1;
    case (st)
      ST_START:  lvl = 1'b0;
      ST_DATA:   lvl = data_bit;
      ST_PARITY: lvl = parity_bit;
      default:   lvl = 1'b1;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/baud_edge_detect.sv
// rtl/baud_edge_detect.sv - samples the divider square wave and emits one tick per rising edge
module baud_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic baud_clk,
  output logic tick
);

  logic baud_q;
  logic baud_q2;

  // Two-flop sample of the divider output; history resets high so a wave
  // that is already high at release does not produce a false tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      baud_q  <= 1'b1;
      baud_q2 <= 1'b1;
    end else begin
      baud_q  <= baud_clk;
      baud_q2 <= baud_q;
    end
  end

  assign tick = baud_q & ~baud_q2;

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter with valid/ready byte input and gap-free back-to-back frames
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 frame_done
);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be 5..8");
  end
  if (PARITY != PARITY_NONE && PARITY != PARITY_EVEN && PARITY != PARITY_ODD) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP  = 1'(STOP_BITS - 1);
  localparam bit         HAS_PARITY = (PARITY != PARITY_NONE);

  // Parity is fixed at accept time so the data register can shift freely.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return (PARITY == PARITY_ODD) ? ~^d : ^d;
  endfunction

  logic tick;

  baud_edge_detect u_edge (
    .clk      (clk),
    .reset    (reset),
    .baud_clk (baud_clk),
    .tick     (tick)
  );

  state_t               state;
  state_t               state_d;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_d;
  logic                 parity_bit;
  logic                 parity_d;
  logic [2:0]           bit_cnt;
  logic [2:0]           bit_cnt_d;
  logic                 stop_cnt;
  logic                 stop_cnt_d;
  logic                 pending;
  logic                 pending_d;
  logic                 tx_d;
  logic                 ready_d;
  logic                 done_d;
  logic                 accept;

  assign accept = tx_valid & tx_ready;

  // Frame sequencing plus the registered line level, ready and done decode
  // of the state being entered.
  always_comb begin
    state_d    = state;
    shift_d    = shift_reg;
    parity_d   = parity_bit;
    bit_cnt_d  = bit_cnt;
    stop_cnt_d = stop_cnt;
    pending_d  = pending;
    done_d     = 1'b0;

    // Ready is only high in IDLE or the final stop bit, neither of which
    // shifts, so loading here never collides with a shift.
    if (accept) begin
      shift_d  = tx_data;
      parity_d = calc_parity(tx_data);
    end

    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (tick) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_reg >> 1;
          if (bit_cnt == LAST_BIT) begin
            state_d    = HAS_PARITY ? ST_PARITY : ST_STOP;
            stop_cnt_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (accept) begin
          pending_d = 1'b1;
        end
        if (tick) begin
          if (stop_cnt != LAST_STOP) begin
            stop_cnt_d = stop_cnt + 1'b1;
          end else begin
            done_d = 1'b1;
            // A byte taken during the last stop bit starts right away.
            if (pending || accept) begin
              state_d   = ST_START;
              pending_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE) ||
              (state_d == ST_STOP && stop_cnt_d == LAST_STOP && !pending_d);
    tx_d    = line_level(state_d, shift_d[0], parity_d);
  end

  // State, datapath and registered outputs; reset abandons any frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      bit_cnt    <= 3'd0;
      stop_cnt   <= 1'b0;
      pending    <= 1'b0;
      tx         <= 1'b1;
      tx_ready   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      shift_reg  <= shift_d;
      parity_bit <= parity_d;
      bit_cnt    <= bit_cnt_d;
      stop_cnt   <= stop_cnt_d;
      pending    <= pending_d;
      tx         <= tx_d;
      tx_ready   <= ready_d;
      frame_done <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx across three frame formats
module tb_uart_tx;

  localparam int NDUT = 3;
  localparam int BIT_CLKS = 32;
  localparam int DB  [NDUT] = '{8, 8, 5};
  localparam int PAR [NDUT] = '{0, 1, 2};
  localparam int SB  [NDUT] = '{1, 2, 1};

  typedef struct {
    logic [15:0] bits;
    int          len;
    int          lat_mode;
    int          acc_cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            baud_clk;
  logic [4:0]      bcnt = 5'd0;
  logic [NDUT-1:0] rst_v;
  logic [NDUT-1:0] valid_v;
  logic [NDUT-1:0] ready_v;
  logic [NDUT-1:0] tx_v;
  logic [NDUT-1:0] fd_v;
  logic [7:0]      data_v [NDUT];

  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  exp_t exp_q [NDUT][$];
  exp_t cur [NDUT];
  bit   busy [NDUT];
  bit   junk [NDUT];
  int   pos [NDUT];
  int   gapless [NDUT];
  int   fd_cnt [NDUT];
  int   exp_done [NDUT];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    bcnt <= bcnt + 5'd1;
  end
  assign baud_clk = bcnt[4];

  uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(rst_v[0]), .baud_clk(baud_clk), .tx_data(data_v[0]),
    .tx_valid(valid_v[0]), .tx_ready(ready_v[0]), .tx(tx_v[0]), .frame_done(fd_v[0]));
  uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u1 (
    .clk(clk), .reset(rst_v[1]), .baud_clk(baud_clk), .tx_data(data_v[1]),
    .tx_valid(valid_v[1]), .tx_ready(ready_v[1]), .tx(tx_v[1]), .frame_done(fd_v[1]));
  uart_tx #(.DATA_BITS(5), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .reset(rst_v[2]), .baud_clk(baud_clk), .tx_data(data_v[2][4:0]),
    .tx_valid(valid_v[2]), .tx_ready(ready_v[2]), .tx(tx_v[2]), .frame_done(fd_v[2]));

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame: start 0, data LSB first, parity from a ones count, stops high.
  function automatic exp_t model(input int i, input logic [7:0] d);
    exp_t e;
    int   ones;
    e.bits    = '1;
    e.len     = 1 + DB[i] + ((PAR[i] != 0) ? 1 : 0) + SB[i];
    e.bits[0] = 1'b0;
    e.lat_mode = 1;
    e.acc_cyc  = 0;
    ones = 0;
    for (int k = 0; k < DB[i]; k++) begin
      e.bits[1+k] = d[k];
      ones += int'(d[k]);
    end
    if (PAR[i] == 1) e.bits[1+DB[i]] = (ones % 2 == 1);
    if (PAR[i] == 2) e.bits[1+DB[i]] = (ones % 2 == 0);
    return e;
  endfunction

  task automatic send(input int i, input logic [7:0] d, input bit keep);
    int   n;
    exp_t e;
    @(negedge clk);
    valid_v[i] = 1'b1;
    data_v[i]  = d;
    n = 0;
    while (!ready_v[i] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!ready_v[i]) begin
      chk("send_wait_ready", int'(ready_v[i]), 1);
      valid_v[i] = 1'b0;
      return;
    end
    e = model(i, d);
    e.acc_cyc = cyc + 1;
    exp_q[i].push_back(e);
    exp_done[i]++;
    @(posedge clk);
    #1;
    if (!keep) valid_v[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while ((busy[i] || exp_q[i].size() != 0 || !ready_v[i]) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("idle_reached_%0d", i), int'(n < 5000), 1);
    chk($sformatf("ready_back_%0d", i), int'(ready_v[i]), 1);
  endtask

  // Monitor: finds each start bit, checks every bit at both ends of its
  // 32-clock window, frame_done exactly at the end, and start latency.
  always @(negedge clk) begin
    bit ended;
    int off;
    for (int i = 0; i < NDUT; i++) begin
      ended = 1'b0;
      if (!rst_v[i]) begin
        busy[i] = 1'b0;
        junk[i] = 1'b0;
      end else begin
        if (fd_v[i]) fd_cnt[i]++;
        if (junk[i] && tx_v[i]) junk[i] = 1'b0;
        if (busy[i] && pos[i] == cur[i].len * BIT_CLKS) begin
          chk($sformatf("frame_done_at_end_%0d", i), int'(fd_v[i]), 1);
          busy[i] = 1'b0;
          ended = 1'b1;
        end else if (fd_v[i]) begin
          chk($sformatf("stray_frame_done_%0d", i), int'(fd_v[i]), 0);
        end
        if (!busy[i] && !junk[i] && !tx_v[i]) begin
          if (exp_q[i].size() == 0) begin
            chk($sformatf("unexpected_frame_%0d", i), exp_q[i].size(), 1);
            junk[i] = 1'b1;
          end else begin
            cur[i]  = exp_q[i].pop_front();
            busy[i] = 1'b1;
            pos[i]  = 0;
            if (ended) gapless[i]++;
            if (cur[i].lat_mode == 2)
              chk($sformatf("start_latency_exact_%0d", i), cyc - cur[i].acc_cyc, BIT_CLKS);
            else
              chk($sformatf("start_latency_in_range_%0d", i),
                  int'((cyc - cur[i].acc_cyc) >= 1 && (cyc - cur[i].acc_cyc) <= BIT_CLKS), 1);
          end
        end
        if (busy[i]) begin
          off = pos[i] % BIT_CLKS;
          if (off == 0 || off == BIT_CLKS - 1)
            chk($sformatf("line_bit%0d_off%0d_dut%0d", pos[i] / BIT_CLKS, off, i),
                int'(tx_v[i]), int'(cur[i].bits[pos[i] / BIT_CLKS]));
          pos[i]++;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   g;
    bit   keep;
    exp_t e;
    rst_v   = '0;
    valid_v = '0;
    for (int i = 0; i < NDUT; i++) begin
      data_v[i] = 8'h00;
      busy[i] = 1'b0; junk[i] = 1'b0; pos[i] = 0;
      gapless[i] = 0; fd_cnt[i] = 0; exp_done[i] = 0;
    end
    repeat (5) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("reset_tx_%0d", i), int'(tx_v[i]), 1);
      chk($sformatf("reset_ready_%0d", i), int'(ready_v[i]), 0);
      chk($sformatf("reset_frame_done_%0d", i), int'(fd_v[i]), 0);
    end
    rst_v = '1;
    @(negedge clk);
    for (int i = 0; i < NDUT; i++)
      chk($sformatf("ready_after_release_%0d", i), int'(ready_v[i]), 1);

    // Plain 8N1 frame, then even and odd parity with 0x03.
    send(0, 8'hA5, 1'b0); wait_idle(0);
    send(1, 8'h03, 1'b0); wait_idle(1);
    send(2, 8'h03, 1'b0); wait_idle(2);

    // Valid held across two bytes: second start must follow with no gap.
    g = gapless[0];
    send(0, 8'h55, 1'b1);
    send(0, 8'hAA, 1'b0);
    wait_idle(0);
    chk("back_to_back_no_gap", gapless[0] - g, 1);

    // Accept coincident with a tick: that tick must not start the frame.
    n = 0;
    while (!u0.u_edge.tick && n < 100) begin
      @(negedge clk);
      n++;
    end
    valid_v[0] = 1'b1;
    data_v[0]  = 8'h81;
    e = model(0, 8'h81);
    e.lat_mode = 2;
    e.acc_cyc  = cyc + 1;
    exp_q[0].push_back(e);
    exp_done[0]++;
    @(posedge clk);
    #1;
    valid_v[0] = 1'b0;
    wait_idle(0);

    // Reset during data bit 4 drops the frame; a fresh byte then goes out.
    send(0, 8'hC3, 1'b0);
    n = 0;
    while (!(busy[0] && pos[0] == 5 * BIT_CLKS + 10) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    rst_v[0] = 1'b0;
    exp_done[0]--;
    @(negedge clk);
    chk("midframe_reset_tx", int'(tx_v[0]), 1);
    chk("midframe_reset_ready", int'(ready_v[0]), 0);
    @(negedge clk);
    rst_v[0] = 1'b1;
    @(negedge clk);
    chk("ready_after_midframe_reset", int'(ready_v[0]), 1);
    send(0, 8'h3C, 1'b0);
    wait_idle(0);

    // Valid pulsed while busy must be ignored.
    send(1, 8'h5A, 1'b0);
    n = 0;
    while (!(busy[1] && pos[1] == 3 * BIT_CLKS + 5) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    valid_v[1] = 1'b1;
    data_v[1]  = 8'hFF;
    repeat (4) @(negedge clk);
    valid_v[1] = 1'b0;
    wait_idle(1);

    // Random bytes with random gaps and occasional held valid.
    for (int i = 0; i < NDUT; i++) begin
      for (int k = 0; k < 6; k++) begin
        keep = (k < 5) && ($urandom_range(0, 2) == 0);
        send(i, 8'($urandom), keep);
        if (!keep) repeat ($urandom_range(0, 40)) @(negedge clk);
      end
      wait_idle(i);
    end

    repeat (4) @(negedge clk);
    for (int i = 0; i < NDUT; i++)
      chk($sformatf("frame_done_count_%0d", i), fd_cnt[i], exp_done[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
